esfa_program_sequencer: RTL and testbench
=========================================

# esfa_program_sequencer

Hardware sequencer that runs a self-checking ESFA test program stored in block ROM. It fetches 56-bit instruction words, issues write or query operations to the ESFA datapath, compares query results against expected values, and reports pass/fail as two bytes through the UART transmitter. It sits between the instruction block memory, the ESFA design, and the UART in the board top level.

## Interface
- `ADDR_W`, 8: ROM address width.
- `LAST_ADDR`, 8'd255: address of the final instruction; execution covers 0..`LAST_ADDR` inclusive.
- `ROM_LAT`, 2: cycles from `rom_addr` change to valid `rom_data`.
- `RES_LAT`, 1: cycles from selector stable to valid ESFA result.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse; begins a run from IDLE or DONE.
- `rom_addr` out `ADDR_W`: instruction address.
- `rom_data` in 56: instruction word. Fields: [0] write, [15:8] index, [23:16] value, [31:24] expected value, [32] expected bool, [47:40] selector, [48] assert. Other bits are ignored.
- `esfa_write` out 1: one-cycle write strobe.
- `esfa_index` out 8, `esfa_value` out 8, `esfa_selector` out 8: ESFA operands.
- `esfa_result_bool` in 1, `esfa_result_value` in 8: ESFA query result.
- `tx_byte` out 8, `tx_start` out 1: UART byte and one-cycle transmit pulse.
- `tx_busy` in 1: UART is_transmitting.
- `busy` out 1, `done` out 1, `pass` out 1, `fail_addr` out `ADDR_W`: run status.

## Operation
- States:
  - IDLE: `start` moves to FETCH and clears `rom_addr`, `pass`, `done`, and `fail_addr`.
  - FETCH: drive `rom_addr`, then wait `ROM_LAT` cycles and go to EXEC.
  - EXEC: latch the instruction word.
    - If assert=1, drive the selector and go to WAIT_RES. The write bit is ignored.
    - Else if write=1, pulse `esfa_write` with index and value, then go to NEXT.
    - Else the instruction is a no-op; go to NEXT.
  - WAIT_RES: hold the selector for `RES_LAT` cycles, then go to CHECK.
  - CHECK: compare the result bool against expected bool and the result value against expected value.
    - Mismatch: set `fail_addr` to the current address and go to REPORT with the fail code.
    - Match: go to NEXT.
  - NEXT: if `rom_addr == LAST_ADDR`, go to REPORT with the pass code. Otherwise increment `rom_addr` and go to FETCH.
  - REPORT: send byte 0 and then byte 1.
    - Pass: 0x50 ('P'), then the number of instructions executed, mod 256.
    - Fail: 0x46 ('F'), then `fail_addr`.
  - DONE: `done`=1. `pass` is 1 only if no mismatch occurred. `start` re-runs the program from FETCH at address 0.
- Address compare uses the full `ADDR_W` bits. When `LAST_ADDR`=255 the run ends after address 255, so the counter never wraps back to 0.
- `esfa_index`, `esfa_value`, and `esfa_selector` hold their last values when not in use. `esfa_write` is strictly one cycle per write instruction.
- A `start` pulse while `busy`=1 is ignored.

## Timing
- Reset values:
  - FSM: IDLE.
  - `rom_addr`, `esfa_index`, `esfa_value`, `esfa_selector`, `tx_byte`, `fail_addr`: 0.
  - `esfa_write`, `tx_start`, `busy`, `done`, `pass`: 0.
- Reset mid-run returns to IDLE on the next edge with no further writes or transmits. A byte already handed to the UART is not aborted.
- Cycles per instruction:
  - Write or no-op: 1 (FETCH) + `ROM_LAT` + 1 (EXEC) + 1 (NEXT).
  - Assert: adds `RES_LAT` + 1 (CHECK).
- `esfa_write` is asserted in the cycle after EXEC decodes the instruction, with index and value valid in the same cycle.
- TX handshake, per byte:
  - Wait until `tx_busy`=0, then drive `tx_byte` and pulse `tx_start` for 1 cycle.
  - Wait until `tx_busy` is seen high, then low, before sending the next byte or entering DONE.
  - `tx_byte` is held from the pulse until the handshake completes.
- `busy`=1 from the cycle after `start` until DONE is entered. `done` rises in the same cycle `busy` falls.
- `pass` and `fail_addr` are stable from entry to DONE until the next `start` or `rst`.

## Test plan
- All-pass program, `LAST_ADDR`=3: write (1,0x11), write (2,0x22), assert sel=2 expecting (1,0x22), no-op. Required: 1-cycle `esfa_write` pulses with index 1 then 2; UART bytes 0x50, 0x04; `pass`=1; `done`=1.
- Mismatch at address 5: the model returns value 0x33 where 0x34 is expected. Required: no fetch beyond address 5; UART bytes 0x46, 0x05; `fail_addr`=5; `pass`=0.
- Expected-bool mismatch alone, with the value matching, at address 0: UART bytes 0x46, 0x00.
- `LAST_ADDR`=255 with 256 no-ops: exactly 256 fetches, no wrap to 0; UART bytes 0x50, 0x00.
- Slow UART: `tx_busy` held high 40 cycles after each `tx_start`. Required: exactly two `tx_start` pulses, with `tx_byte` stable throughout. A `start` pulse during the run is ignored.
- Assert `rst` during WAIT_RES at address 2, then pulse `start`. Required: all outputs at reset values the cycle after reset; the rerun begins at address 0 and completes normally.

Source files
------------

// File: rtl/esfa_program_sequencer.sv
// Runs a self-checking ESFA test program from instruction ROM and reports
// the outcome as two UART bytes: 'P' + instruction count, or 'F' + failing address.
module esfa_program_sequencer #(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] LAST_ADDR = 8'd255,
  parameter int                ROM_LAT   = 2,
  parameter int                RES_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [55:0]       rom_data,
  output logic              esfa_write,
  output logic [7:0]        esfa_index,
  output logic [7:0]        esfa_value,
  output logic [7:0]        esfa_selector,
  input  logic              esfa_result_bool,
  input  logic [7:0]        esfa_result_value,
  output logic [7:0]        tx_byte,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr
);

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_FETCH    = 4'd1;
  localparam logic [3:0] ST_WAIT_ROM = 4'd2;
  localparam logic [3:0] ST_EXEC     = 4'd3;
  localparam logic [3:0] ST_WAIT_RES = 4'd4;
  localparam logic [3:0] ST_CHECK    = 4'd5;
  localparam logic [3:0] ST_NEXT     = 4'd6;
  localparam logic [3:0] ST_REPORT   = 4'd7;
  localparam logic [3:0] ST_TX_HI    = 4'd8;
  localparam logic [3:0] ST_TX_LO    = 4'd9;
  localparam logic [3:0] ST_DONE     = 4'd10;

  localparam logic [7:0]        ROM_WAIT = 8'(ROM_LAT - 1);
  localparam logic [7:0]        RES_WAIT = 8'(RES_LAT - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [7:0]        CODE_PASS = 8'h50;
  localparam logic [7:0]        CODE_FAIL = 8'h46;

  logic [3:0] state_r;
  logic [7:0] cnt_r;
  logic [7:0] exp_value_r;
  logic       exp_bool_r;
  logic       mismatch_r;
  logic       byte_sel_r;
  logic [7:0] instr_cnt_r;
  logic       rom_unused_s;

  // Instruction bits outside the decoded fields carry no meaning here.
  assign rom_unused_s = ^{rom_data[7:1], rom_data[39:33], rom_data[55:49]};

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      cnt_r         <= 8'd0;
      exp_value_r   <= 8'd0;
      exp_bool_r    <= 1'b0;
      mismatch_r    <= 1'b0;
      byte_sel_r    <= 1'b0;
      instr_cnt_r   <= 8'd0;
      rom_addr      <= '0;
      esfa_write    <= 1'b0;
      esfa_index    <= 8'd0;
      esfa_value    <= 8'd0;
      esfa_selector <= 8'd0;
      tx_byte       <= 8'd0;
      tx_start      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      fail_addr     <= '0;
    end else begin
      esfa_write <= 1'b0;
      tx_start   <= 1'b0;
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            rom_addr    <= '0;
            pass        <= 1'b0;
            done        <= 1'b0;
            fail_addr   <= '0;
            busy        <= 1'b1;
            mismatch_r  <= 1'b0;
            byte_sel_r  <= 1'b0;
            instr_cnt_r <= 8'd0;
            state_r     <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (ROM_LAT == 0) begin
            state_r <= ST_EXEC;
          end else begin
            cnt_r   <= ROM_WAIT;
            state_r <= ST_WAIT_ROM;
          end
        end
        ST_WAIT_ROM: begin
          if (cnt_r == 8'd0) state_r <= ST_EXEC;
          else               cnt_r   <= cnt_r - 8'd1;
        end
        ST_EXEC: begin
          instr_cnt_r <= instr_cnt_r + 8'd1;
          exp_value_r <= rom_data[31:24];
          exp_bool_r  <= rom_data[32];
          // The assert bit takes priority; a set write bit is then ignored.
          if (rom_data[48]) begin
            esfa_selector <= rom_data[47:40];
            if (RES_LAT == 0) begin
              state_r <= ST_CHECK;
            end else begin
              cnt_r   <= RES_WAIT;
              state_r <= ST_WAIT_RES;
            end
          end else if (rom_data[0]) begin
            esfa_index <= rom_data[15:8];
            esfa_value <= rom_data[23:16];
            esfa_write <= 1'b1;
            state_r    <= ST_NEXT;
          end else begin
            state_r <= ST_NEXT;
          end
        end
        ST_WAIT_RES: begin
          if (cnt_r == 8'd0) state_r <= ST_CHECK;
          else               cnt_r   <= cnt_r - 8'd1;
        end
        ST_CHECK: begin
          if ((esfa_result_bool != exp_bool_r) || (esfa_result_value != exp_value_r)) begin
            fail_addr  <= rom_addr;
            mismatch_r <= 1'b1;
            byte_sel_r <= 1'b0;
            state_r    <= ST_REPORT;
          end else begin
            state_r <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          // Stop at LAST_ADDR before incrementing so the address never wraps.
          if (rom_addr == LAST_ADDR) begin
            byte_sel_r <= 1'b0;
            state_r    <= ST_REPORT;
          end else begin
            rom_addr <= rom_addr + ADDR_ONE;
            state_r  <= ST_FETCH;
          end
        end
        ST_REPORT: begin
          if (!tx_busy) begin
            if (byte_sel_r) tx_byte <= mismatch_r ? 8'(fail_addr) : instr_cnt_r;
            else            tx_byte <= mismatch_r ? CODE_FAIL : CODE_PASS;
            tx_start <= 1'b1;
            state_r  <= ST_TX_HI;
          end
        end
        ST_TX_HI: begin
          if (tx_busy) state_r <= ST_TX_LO;
        end
        ST_TX_LO: begin
          if (!tx_busy) begin
            if (byte_sel_r) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              pass    <= ~mismatch_r;
              state_r <= ST_DONE;
            end else begin
              byte_sel_r <= 1'b1;
              state_r    <= ST_REPORT;
            end
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_esfa_program_sequencer.sv
// Directed bench: two sequencers (LAST_ADDR 3 and 255) each with its own ROM,
// ESFA memory model and UART model.
module tb_esfa_program_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, start_b;
  logic [7:0]  rom_addr_a, rom_addr_b;
  logic [55:0] rom_data_a, rom_data_b, rom_pipe_a, rom_pipe_b;
  logic        esfa_write_a, esfa_write_b;
  logic [7:0]  esfa_index_a, esfa_index_b, esfa_value_a, esfa_value_b;
  logic [7:0]  esfa_selector_a, esfa_selector_b;
  logic        esfa_result_bool_a, esfa_result_bool_b;
  logic [7:0]  esfa_result_value_a, esfa_result_value_b;
  logic [7:0]  tx_byte_a, tx_byte_b;
  logic        tx_start_a, tx_start_b, tx_busy_a, tx_busy_b;
  logic        busy_a, busy_b, done_a, done_b, pass_a, pass_b;
  logic [7:0]  fail_addr_a, fail_addr_b;

  logic [55:0] rom_a [0:255];
  logic [55:0] rom_b [0:255];
  logic [7:0]  mem_a [0:255];
  logic [7:0]  mem_b [0:255];
  logic [7:0]  ucnt_a = 8'd0;
  logic [7:0]  ucnt_b = 8'd0;
  logic [7:0]  uart_delay_a, uart_delay_b;

  logic [7:0]  wr_idx_q [$];
  logic [7:0]  wr_val_q [$];
  int          wr_cyc_q [$];
  logic [7:0]  tx_q_a [$];
  logic [7:0]  tx_q_b [$];
  logic [7:0]  held_a = 8'd0;
  int          unstable_a = 0;
  logic [7:0]  prev_addr_b = 8'd0;
  int          incs_b = 0;
  int          wraps_b = 0;
  int          cyc = 0;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  esfa_program_sequencer #(.ADDR_W(8), .LAST_ADDR(8'd3), .ROM_LAT(2), .RES_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .rom_addr(rom_addr_a), .rom_data(rom_data_a),
    .esfa_write(esfa_write_a), .esfa_index(esfa_index_a), .esfa_value(esfa_value_a),
    .esfa_selector(esfa_selector_a), .esfa_result_bool(esfa_result_bool_a),
    .esfa_result_value(esfa_result_value_a), .tx_byte(tx_byte_a), .tx_start(tx_start_a),
    .tx_busy(tx_busy_a), .busy(busy_a), .done(done_a), .pass(pass_a), .fail_addr(fail_addr_a));

  esfa_program_sequencer #(.ADDR_W(8), .LAST_ADDR(8'd255), .ROM_LAT(2), .RES_LAT(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .rom_addr(rom_addr_b), .rom_data(rom_data_b),
    .esfa_write(esfa_write_b), .esfa_index(esfa_index_b), .esfa_value(esfa_value_b),
    .esfa_selector(esfa_selector_b), .esfa_result_bool(esfa_result_bool_b),
    .esfa_result_value(esfa_result_value_b), .tx_byte(tx_byte_b), .tx_start(tx_start_b),
    .tx_busy(tx_busy_b), .busy(busy_b), .done(done_b), .pass(pass_b), .fail_addr(fail_addr_b));

  // Two-stage ROM, ESFA register file and UART busy counters.
  always @(posedge clk) begin
    cyc        <= cyc + 1;
    rom_pipe_a <= rom_a[rom_addr_a];
    rom_data_a <= rom_pipe_a;
    rom_pipe_b <= rom_b[rom_addr_b];
    rom_data_b <= rom_pipe_b;
    if (rst) begin
      for (int i = 0; i < 256; i++) begin
        mem_a[i] <= 8'd0;
        mem_b[i] <= 8'd0;
      end
    end else begin
      if (esfa_write_a) mem_a[esfa_index_a] <= esfa_value_a;
      if (esfa_write_b) mem_b[esfa_index_b] <= esfa_value_b;
    end
    if (tx_start_a)           ucnt_a <= uart_delay_a;
    else if (ucnt_a != 8'd0)  ucnt_a <= ucnt_a - 8'd1;
    if (tx_start_b)           ucnt_b <= uart_delay_b;
    else if (ucnt_b != 8'd0)  ucnt_b <= ucnt_b - 8'd1;
  end

  assign esfa_result_value_a = mem_a[esfa_selector_a];
  assign esfa_result_bool_a  = |mem_a[esfa_selector_a];
  assign esfa_result_value_b = mem_b[esfa_selector_b];
  assign esfa_result_bool_b  = |mem_b[esfa_selector_b];
  assign tx_busy_a = (ucnt_a != 8'd0);
  assign tx_busy_b = (ucnt_b != 8'd0);

  // Mid-cycle monitors logging writes, UART bytes and address movement.
  always @(negedge clk) begin
    if (esfa_write_a) begin
      wr_idx_q.push_back(esfa_index_a);
      wr_val_q.push_back(esfa_value_a);
      wr_cyc_q.push_back(cyc);
    end
    if (tx_start_a) begin
      tx_q_a.push_back(tx_byte_a);
      held_a <= tx_byte_a;
    end
    if (tx_busy_a && (tx_byte_a !== held_a)) unstable_a <= unstable_a + 1;
    if (tx_start_b) tx_q_b.push_back(tx_byte_b);
    if (rom_addr_b !== prev_addr_b) begin
      if (prev_addr_b == 8'd255 && rom_addr_b == 8'd0) wraps_b <= wraps_b + 1;
      else if (rom_addr_b == prev_addr_b + 8'd1)       incs_b  <= incs_b + 1;
      prev_addr_b <= rom_addr_b;
    end
  end

  function automatic logic [55:0] ins(input logic wr, input logic as, input logic [7:0] idx,
                                      input logic [7:0] val, input logic [7:0] expv,
                                      input logic expb, input logic [7:0] sel);
    logic [55:0] w;
    w = 56'd0;
    w[0] = wr; w[15:8] = idx; w[23:16] = val; w[31:24] = expv;
    w[32] = expb; w[47:40] = sel; w[48] = as;
    return w;
  endfunction

  task automatic pulse_start(input bit use_b);
    @(negedge clk);
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_done(input bit use_b, input int bound, output int cycles, output bit prev_busy);
    cycles = 0;
    prev_busy = 1'b0;
    while (cycles < bound) begin
      @(negedge clk);
      cycles++;
      if (use_b ? done_b : done_a) break;
      prev_busy = use_b ? busy_b : busy_a;
    end
  endtask

  task automatic load_pass_a(input logic [7:0] sel, input logic [7:0] expv);
    for (int i = 0; i < 256; i++) rom_a[i] = 56'd0;
    rom_a[0] = ins(1'b1, 1'b0, 8'd1, 8'h11, 8'h00, 1'b0, 8'h00);
    rom_a[1] = ins(1'b1, 1'b0, 8'd2, 8'h22, 8'h00, 1'b0, 8'h00);
    rom_a[2] = ins(1'b1, 1'b1, 8'd9, 8'h99, expv, 1'b1, sel);
    rom_a[3] = 56'hFE_00_FE_00_00_00_FE;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({rom_addr_a, esfa_index_a, esfa_value_a, esfa_selector_a, tx_byte_a, fail_addr_a,
         esfa_write_a, tx_start_a, busy_a, done_a, pass_a} !== 53'd0)
      $display("FAIL reset_a: outputs not all zero (addr=%h busy=%b done=%b)", rom_addr_a, busy_a, done_a);
    else passed++;
    checks++;
    if ({rom_addr_b, esfa_index_b, esfa_value_b, esfa_selector_b, tx_byte_b, fail_addr_b,
         esfa_write_b, tx_start_b, busy_b, done_b, pass_b} !== 53'd0)
      $display("FAIL reset_b: outputs not all zero (addr=%h busy=%b done=%b)", rom_addr_b, busy_b, done_b);
    else passed++;
    rst = 1'b0;
  endtask

  task automatic check_run(input string name, input bit use_b, input int bound,
                           input logic [7:0] b0, input logic [7:0] b1,
                           input logic exp_pass, input int tx_base, output int cycles);
    bit pb;
    logic [7:0] got0, got1;
    int n;
    wait_done(use_b, bound, cycles, pb);
    checks++;
    if ((use_b ? done_b : done_a) !== 1'b1) $display("FAIL %s_done: done=0 after %0d cycles, required 1", name, cycles);
    else passed++;
    checks++;
    if ({pb, (use_b ? busy_b : busy_a)} !== 2'b10)
      $display("FAIL %s_busy: busy before/at done = %b, required 10", name, {pb, (use_b ? busy_b : busy_a)});
    else passed++;
    n    = use_b ? tx_q_b.size() - tx_base : tx_q_a.size() - tx_base;
    got0 = (n > 0) ? (use_b ? tx_q_b[tx_base] : tx_q_a[tx_base]) : 8'hxx;
    got1 = (n > 1) ? (use_b ? tx_q_b[tx_base+1] : tx_q_a[tx_base+1]) : 8'hxx;
    checks++;
    if (n != 2 || got0 !== b0 || got1 !== b1)
      $display("FAIL %s_uart: %0d bytes %h %h, required 2 bytes %h %h", name, n, got0, got1, b0, b1);
    else passed++;
    checks++;
    if ((use_b ? pass_b : pass_a) !== exp_pass)
      $display("FAIL %s_pass: pass=%b, required %b", name, (use_b ? pass_b : pass_a), exp_pass);
    else passed++;
  endtask

  task automatic test_all_pass();
    int wb, tb, cyc_n;
    load_pass_a(8'd2, 8'h22);
    wb = wr_idx_q.size();
    tb = tx_q_a.size();
    pulse_start(1'b0);
    check_run("all_pass", 1'b0, 500, 8'h50, 8'h04, 1'b1, tb, cyc_n);
    checks++;
    if (cyc_n != 34) $display("FAIL all_pass_latency: done after %0d cycles, required 34", cyc_n);
    else passed++;
    checks++;
    if (wr_idx_q.size() - wb != 2) $display("FAIL all_pass_writes: %0d write cycles, required 2", wr_idx_q.size() - wb);
    else if ({wr_idx_q[wb], wr_val_q[wb], wr_idx_q[wb+1], wr_val_q[wb+1]} !== 32'h01_11_02_22)
      $display("FAIL all_pass_write_data: got %h %h %h %h, required 01 11 02 22",
               wr_idx_q[wb], wr_val_q[wb], wr_idx_q[wb+1], wr_val_q[wb+1]);
    else if (wr_cyc_q[wb+1] - wr_cyc_q[wb] != 5)
      $display("FAIL all_pass_write_gap: %0d cycles, required 5", wr_cyc_q[wb+1] - wr_cyc_q[wb]);
    else passed++;
    checks++;
    if (fail_addr_a !== 8'd0) $display("FAIL all_pass_fail_addr: got %h, required 00", fail_addr_a);
    else passed++;
  endtask

  task automatic test_mismatch();
    int tb, ib, cyc_n;
    for (int i = 0; i < 256; i++) rom_b[i] = 56'd0;
    rom_b[0] = ins(1'b1, 1'b0, 8'd5, 8'h33, 8'h00, 1'b0, 8'h00);
    rom_b[2] = ins(1'b0, 1'b1, 8'd0, 8'h00, 8'h33, 1'b1, 8'd5);
    rom_b[4] = ins(1'b1, 1'b0, 8'd6, 8'h10, 8'h00, 1'b0, 8'h00);
    rom_b[5] = ins(1'b0, 1'b1, 8'd0, 8'h00, 8'h34, 1'b1, 8'd5);
    tb = tx_q_b.size();
    ib = incs_b;
    pulse_start(1'b1);
    check_run("mismatch", 1'b1, 2000, 8'h46, 8'h05, 1'b0, tb, cyc_n);
    checks++;
    if (fail_addr_b !== 8'd5) $display("FAIL mismatch_fail_addr: got %h, required 05", fail_addr_b);
    else passed++;
    checks++;
    if (incs_b - ib != 5 || rom_addr_b !== 8'd5)
      $display("FAIL mismatch_fetch: %0d increments, addr %h, required 5 increments, addr 05", incs_b - ib, rom_addr_b);
    else passed++;
  endtask

  task automatic test_bool_mismatch();
    int tb, cyc_n;
    for (int i = 0; i < 256; i++) rom_a[i] = 56'd0;
    rom_a[0] = ins(1'b0, 1'b1, 8'd0, 8'h00, 8'h00, 1'b1, 8'h10);
    tb = tx_q_a.size();
    pulse_start(1'b0);
    check_run("bool_mismatch", 1'b0, 500, 8'h46, 8'h00, 1'b0, tb, cyc_n);
  endtask

  task automatic test_full_program();
    int tb, ib, wb, cyc_n;
    for (int i = 0; i < 256; i++) rom_b[i] = 56'd0;
    tb = tx_q_b.size();
    ib = incs_b;
    wb = wraps_b;
    pulse_start(1'b1);
    check_run("full_256", 1'b1, 5000, 8'h50, 8'h00, 1'b1, tb, cyc_n);
    repeat (3) @(negedge clk);
    checks++;
    if (incs_b - ib != 255 || wraps_b != wb || rom_addr_b !== 8'd255)
      $display("FAIL full_256_fetch: %0d increments, %0d wraps, addr %h, required 255, 0, ff",
               incs_b - ib, wraps_b - wb, rom_addr_b);
    else passed++;
  endtask

  task automatic test_slow_uart();
    int tb, wb, ub, cyc_n;
    uart_delay_a = 8'd40;
    load_pass_a(8'd2, 8'h22);
    tb = tx_q_a.size();
    wb = wr_idx_q.size();
    ub = unstable_a;
    pulse_start(1'b0);
    repeat (8) @(negedge clk);
    pulse_start(1'b0);
    repeat (40) @(negedge clk);
    pulse_start(1'b0);
    check_run("slow_uart", 1'b0, 1000, 8'h50, 8'h04, 1'b1, tb, cyc_n);
    checks++;
    if (unstable_a != ub) $display("FAIL slow_uart_hold: tx_byte changed %0d times while busy, required 0", unstable_a - ub);
    else passed++;
    checks++;
    if (wr_idx_q.size() - wb != 2) $display("FAIL slow_uart_restart: %0d write cycles, required 2", wr_idx_q.size() - wb);
    else passed++;
    uart_delay_a = 8'd3;
  endtask

  task automatic test_reset_midrun();
    int k, tb, wb, cyc_n;
    load_pass_a(8'd1, 8'h11);
    pulse_start(1'b0);
    k = 0;
    while (k < 100 && !(esfa_selector_a == 8'd1 && rom_addr_a == 8'd2)) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k >= 100) $display("FAIL midrun_reach: WAIT_RES at address 2 not seen, selector=%h addr=%h", esfa_selector_a, rom_addr_a);
    else passed++;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({rom_addr_a, esfa_index_a, esfa_value_a, esfa_selector_a, tx_byte_a, fail_addr_a,
         esfa_write_a, tx_start_a, busy_a, done_a, pass_a} !== 53'd0)
      $display("FAIL midrun_reset: outputs not zero (addr=%h sel=%h busy=%b)", rom_addr_a, esfa_selector_a, busy_a);
    else passed++;
    rst = 1'b0;
    tb = tx_q_a.size();
    wb = wr_idx_q.size();
    repeat (6) @(negedge clk);
    checks++;
    if (tx_q_a.size() != tb || wr_idx_q.size() != wb || busy_a !== 1'b0)
      $display("FAIL midrun_quiet: %0d tx, %0d writes, busy=%b after reset, required 0 0 0",
               tx_q_a.size() - tb, wr_idx_q.size() - wb, busy_a);
    else passed++;
    pulse_start(1'b0);
    check_run("midrun_rerun", 1'b0, 500, 8'h50, 8'h04, 1'b1, tb, cyc_n);
    checks++;
    if (wr_idx_q.size() - wb != 2 || wr_idx_q[wb] !== 8'd1)
      $display("FAIL midrun_rerun_writes: %0d writes, first index %h, required 2 starting at 01",
               wr_idx_q.size() - wb, wr_idx_q[wb]);
    else passed++;
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    uart_delay_a = 8'd3;
    uart_delay_b = 8'd3;
    for (int i = 0; i < 256; i++) begin
      rom_a[i] = 56'd0;
      rom_b[i] = 56'd0;
    end
    test_reset();
    test_all_pass();
    test_mismatch();
    test_bool_mismatch();
    test_full_program();
    test_slow_uart();
    test_reset_midrun();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
